dma_chan_sched: RTL and testbench

- Multi-channel front end for the single-channel DMA function wrapper. Accepts up to NUM_CH independent transfer requests, each a src/dst/bytes descriptor.
- Arbitrates round-robin, launches one transfer at a time on the engine's go/desc interface, and waits for engine completion or error.
- Reports per-channel done/error pulses, so several masters or CSR banks can share one DMA datapath.

---
 rtl/dma_chan_sched.sv | 193 +++++++++++++++++++
 tb/tb_dma_chan_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chan_sched.sv
// dma_chan_sched: round-robin multi-channel front end for one DMA engine.
// Optional engine watchdog is enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_chan_sched #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 32,
    parameter int BYTES_W     = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_go_i,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_src_i,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_dst_i,
    input  logic [NUM_CH*BYTES_W-1:0] ch_bytes_i,
    input  logic [NUM_CH-1:0]         ch_abort_i,
    output logic [NUM_CH-1:0]         ch_busy_o,
    output logic [NUM_CH-1:0]         ch_done_o,
    output logic [NUM_CH-1:0]         ch_err_o,
    output logic [1:0]                err_code_o,
    output logic [ADDR_W-1:0]         err_addr_o,
    output logic [$clog2(NUM_CH)-1:0] active_ch_o,
    output logic                      sched_busy_o,
    output logic                      eng_go_o,
    output logic [ADDR_W-1:0]         eng_src_o,
    output logic [ADDR_W-1:0]         eng_dst_o,
    output logic [BYTES_W-1:0]        eng_bytes_o,
    input  logic                      eng_done_i,
    input  logic                      eng_err_i,
    input  logic [ADDR_W-1:0]         eng_err_addr_i
);

    localparam int CW = $clog2(NUM_CH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_CPL    = 2'd3;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_PEND = 2'd1;
    localparam logic [1:0] C_ACT  = 2'd2;

    localparam logic [1:0] E_ABORT = 2'd0;
    localparam logic [1:0] E_ENG   = 2'd1;
    localparam logic [1:0] E_ZERO  = 2'd2;
    localparam logic [1:0] E_TMO   = 2'd3;

    logic [1:0]         state;
    logic [1:0]         ch_st   [NUM_CH];
    logic [ADDR_W-1:0]  src_q   [NUM_CH];
    logic [ADDR_W-1:0]  dst_q   [NUM_CH];
    logic [BYTES_W-1:0] bytes_q [NUM_CH];
    logic [CW-1:0]      rr;
    logic [NUM_CH-1:0]  pend;
    logic [NUM_CH-1:0]  rel;
    logic               found;
    logic [CW-1:0]      gnt;
    logic [CW-1:0]      idx;

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    // An abort in the same cycle removes the channel from arbitration.
    always_comb begin
        pend      = '0;
        rel       = '0;
        ch_busy_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pend[c]      = (ch_st[c] == C_PEND) && !ch_abort_i[c];
            rel[c]       = (state == S_CPL) && (active_ch_o == CW'(c));
            ch_busy_o[c] = (ch_st[c] != C_IDLE);
        end
    end

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CW'((int'(rr) + i) % NUM_CH);
            if (!found && pend[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rr           <= CW'(NUM_CH - 1);
            ch_done_o    <= '0;
            ch_err_o     <= '0;
            err_code_o   <= '0;
            err_addr_o   <= '0;
            active_ch_o  <= '0;
            sched_busy_o <= 1'b0;
            eng_go_o     <= 1'b0;
            eng_src_o    <= '0;
            eng_dst_o    <= '0;
            eng_bytes_o  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_st[c]   <= C_IDLE;
                src_q[c]   <= '0;
                dst_q[c]   <= '0;
                bytes_q[c] <= '0;
            end
`ifdef DMA_SCHED_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            ch_done_o <= '0;
            ch_err_o  <= '0;
            eng_go_o  <= 1'b0;

            // A channel released in S_CPL already counts as idle for a new go.
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_st[c] == C_PEND && ch_abort_i[c]) begin
                    ch_st[c]    <= C_IDLE;
                    ch_err_o[c] <= 1'b1;
                    err_code_o  <= E_ABORT;
                end else if ((ch_st[c] == C_IDLE || rel[c]) && ch_go_i[c]) begin
                    if (ch_bytes_i[c*BYTES_W +: BYTES_W] == '0) begin
                        ch_st[c]    <= C_IDLE;
                        ch_err_o[c] <= 1'b1;
                        err_code_o  <= E_ZERO;
                    end else begin
                        ch_st[c]   <= C_PEND;
                        src_q[c]   <= ch_src_i[c*ADDR_W +: ADDR_W];
                        dst_q[c]   <= ch_dst_i[c*ADDR_W +: ADDR_W];
                        bytes_q[c] <= ch_bytes_i[c*BYTES_W +: BYTES_W];
                    end
                end else if (rel[c]) begin
                    ch_st[c] <= C_IDLE;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        ch_st[gnt]   <= C_ACT;
                        eng_src_o    <= src_q[gnt];
                        eng_dst_o    <= dst_q[gnt];
                        eng_bytes_o  <= bytes_q[gnt];
                        active_ch_o  <= gnt;
                        sched_busy_o <= 1'b1;
                        state        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    eng_go_o <= 1'b1;
                    state    <= S_WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                end
                S_WAIT: begin
                    if (eng_err_i) begin
                        err_addr_o            <= eng_err_addr_i;
                        ch_err_o[active_ch_o] <= 1'b1;
                        err_code_o            <= E_ENG;
                        state                 <= S_CPL;
                    end else if (eng_done_i) begin
                        ch_done_o[active_ch_o] <= 1'b1;
                        state                  <= S_CPL;
`ifdef DMA_SCHED_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        ch_err_o[active_ch_o] <= 1'b1;
                        err_code_o            <= E_TMO;
                        state                 <= S_CPL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                S_CPL: begin
                    rr           <= active_ch_o;
                    sched_busy_o <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_chan_sched.sv
// tb_dma_chan_sched: directed table plus hand sequences for dma_chan_sched.
// Timeout checks follow DMA_SCHED_TIMEOUT_EN with TIMEOUT_CYC=16.
module tb_dma_chan_sched;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int BW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [NC-1:0]  ch_go_i;
    logic [NC*AW-1:0] ch_src_i;
    logic [NC*AW-1:0] ch_dst_i;
    logic [NC*BW-1:0] ch_bytes_i;
    logic [NC-1:0]  ch_abort_i;
    logic [NC-1:0]  ch_busy_o;
    logic [NC-1:0]  ch_done_o;
    logic [NC-1:0]  ch_err_o;
    logic [1:0]     err_code_o;
    logic [AW-1:0]  err_addr_o;
    logic [1:0]     active_ch_o;
    logic           sched_busy_o;
    logic           eng_go_o;
    logic [AW-1:0]  eng_src_o;
    logic [AW-1:0]  eng_dst_o;
    logic [BW-1:0]  eng_bytes_o;
    logic           eng_done_i;
    logic           eng_err_i;
    logic [AW-1:0]  eng_err_addr_i;

    int n_chk = 0;
    int n_fail = 0;

    dma_chan_sched #(
        .NUM_CH(NC), .ADDR_W(AW), .BYTES_W(BW), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_go_i(ch_go_i), .ch_src_i(ch_src_i),
        .ch_dst_i(ch_dst_i), .ch_bytes_i(ch_bytes_i),
        .ch_abort_i(ch_abort_i), .ch_busy_o(ch_busy_o),
        .ch_done_o(ch_done_o), .ch_err_o(ch_err_o),
        .err_code_o(err_code_o), .err_addr_o(err_addr_o),
        .active_ch_o(active_ch_o), .sched_busy_o(sched_busy_o),
        .eng_go_o(eng_go_o), .eng_src_o(eng_src_o),
        .eng_dst_o(eng_dst_o), .eng_bytes_o(eng_bytes_o),
        .eng_done_i(eng_done_i), .eng_err_i(eng_err_i),
        .eng_err_addr_i(eng_err_addr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] go;
        logic       done;
        logic [3:0] x_busy;
        logic [3:0] x_done;
        logic       x_go;
        logic       x_sb;
    } vec_t;

    vec_t tv [14];

    function automatic vec_t mk(logic [3:0] go, logic done,
                                logic [3:0] busy, logic [3:0] dn,
                                logic xg, logic sb);
        vec_t v;
        v.go = go; v.done = done; v.x_busy = busy;
        v.x_done = dn; v.x_go = xg; v.x_sb = sb;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bytes(input logic [31:0] b);
        for (int c = 0; c < NC; c++) ch_bytes_i[c*BW +: BW] = b;
    endtask

    task automatic pulse_go(input logic [3:0] m, input logic [31:0] b);
        set_bytes(b);
        ch_go_i = m;
        tick();
        ch_go_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_go();
        int n = 0;
        while (!eng_go_o && n < 20) begin
            tick();
            n++;
        end
        check("wait_eng_go", 64'(eng_go_o), 64'(1));
    endtask

    task automatic run_one(input int ch, input int lat);
        wait_go();
        check("launch_ch", 64'(active_ch_o), 64'(ch));
        check("launch_src", 64'(eng_src_o), 64'(32'h1000 * ch));
        repeat (lat) tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        check("done_pulse", 64'(ch_done_o), 64'(1) << ch);
    endtask

    initial begin
        int gc;
        rst = 1'b1;
        ch_go_i = '0;
        ch_abort_i = '0;
        eng_done_i = 1'b0;
        eng_err_i = 1'b0;
        eng_err_addr_i = '0;
        for (int c = 0; c < NC; c++) begin
            ch_src_i[c*AW +: AW] = 32'h1000 * c;
            ch_dst_i[c*AW +: AW] = 32'h2000 * c;
        end
        set_bytes(32'd64);

        tv[0]  = mk(4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0);
        tv[1]  = mk(4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1);
        tv[2]  = mk(4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1);
        for (int i = 3; i < 12; i++)
            tv[i] = mk(4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1);
        tv[12] = mk(4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1);
        tv[13] = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        tick();
        tick();
        check("rst_busy", 64'(ch_busy_o), 64'(0));
        check("rst_sb", 64'(sched_busy_o), 64'(0));
        check("rst_go", 64'(eng_go_o), 64'(0));
        check("rst_err", 64'(ch_err_o), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            ch_go_i = tv[i].go;
            eng_done_i = tv[i].done;
            tick();
            ch_go_i = '0;
            eng_done_i = 1'b0;
            check($sformatf("tv%0d_busy", i), 64'(ch_busy_o), 64'(tv[i].x_busy));
            check($sformatf("tv%0d_done", i), 64'(ch_done_o), 64'(tv[i].x_done));
            check($sformatf("tv%0d_err", i), 64'(ch_err_o), 64'(0));
            check($sformatf("tv%0d_go", i), 64'(eng_go_o), 64'(tv[i].x_go));
            check($sformatf("tv%0d_sb", i), 64'(sched_busy_o), 64'(tv[i].x_sb));
            if (tv[i].x_sb)
                check($sformatf("tv%0d_ach", i), 64'(active_ch_o), 64'(1));
            if (tv[i].x_go) begin
                check("desc_src", 64'(eng_src_o), 64'(32'h1000));
                check("desc_dst", 64'(eng_dst_o), 64'(32'h2000));
                check("desc_bytes", 64'(eng_bytes_o), 64'(64));
            end
        end

        // Round robin from a fresh reset
        do_reset();
        pulse_go(4'b1101, 32'd8);
        run_one(0, 5);
        run_one(2, 5);
        run_one(3, 5);
        tick();
        check("rr_idle", 64'(ch_busy_o), 64'(0));
        pulse_go(4'b1001, 32'd8);
        run_one(0, 5);
        run_one(3, 5);
        tick();

        // Re-request in the completion cycle
        pulse_go(4'b0010, 32'd16);
        wait_go();
        tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        check("rereq_done", 64'(ch_done_o), 64'(4'b0010));
        ch_go_i = 4'b0010;
        tick();
        ch_go_i = '0;
        check("rereq_pend", 64'(ch_busy_o), 64'(4'b0010));
        check("rereq_sb", 64'(sched_busy_o), 64'(0));
        run_one(1, 2);
        tick();

        // Zero length
        pulse_go(4'b0100, 32'd0);
        check("zl_err", 64'(ch_err_o), 64'(4'b0100));
        check("zl_code", 64'(err_code_o), 64'(2));
        check("zl_busy", 64'(ch_busy_o), 64'(0));
        tick();
        check("zl_err_clr", 64'(ch_err_o), 64'(0));
        check("zl_nogo", 64'(eng_go_o), 64'(0));
        check("zl_code_hold", 64'(err_code_o), 64'(2));

        // Abort a pending channel queued behind an active one
        pulse_go(4'b0001, 32'd16);
        wait_go();
        pulse_go(4'b0010, 32'd16);
        check("ab_busy", 64'(ch_busy_o), 64'(4'b0011));
        ch_abort_i = 4'b0010;
        tick();
        ch_abort_i = '0;
        check("ab_err", 64'(ch_err_o), 64'(4'b0010));
        check("ab_code", 64'(err_code_o), 64'(0));
        check("ab_busy2", 64'(ch_busy_o), 64'(4'b0001));
        repeat (2) tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        check("ab_done0", 64'(ch_done_o), 64'(4'b0001));
        gc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (eng_go_o) gc++;
        end
        check("ab_nolaunch", 64'(gc), 64'(0));
        check("ab_idle", 64'(ch_busy_o), 64'(0));

        // Engine error and done together
        pulse_go(4'b1000, 32'd16);
        wait_go();
        tick();
        eng_err_i = 1'b1;
        eng_done_i = 1'b1;
        eng_err_addr_i = 32'hDEAD0;
        tick();
        eng_err_i = 1'b0;
        eng_done_i = 1'b0;
        eng_err_addr_i = '0;
        check("ee_err", 64'(ch_err_o), 64'(4'b1000));
        check("ee_nodone", 64'(ch_done_o), 64'(0));
        check("ee_code", 64'(err_code_o), 64'(1));
        check("ee_addr", 64'(err_addr_o), 64'(32'hDEAD0));
        tick();
        check("ee_idle", 64'(ch_busy_o), 64'(0));
        check("ee_sb", 64'(sched_busy_o), 64'(0));

        // Engine never responds
        pulse_go(4'b0100, 32'd4);
        wait_go();
`ifdef DMA_SCHED_TIMEOUT_EN
        repeat (15) tick();
        check("tmo_early", 64'(ch_err_o), 64'(0));
        tick();
        check("tmo_err", 64'(ch_err_o), 64'(4'b0100));
        check("tmo_code", 64'(err_code_o), 64'(3));
        tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        check("tmo_late_done", 64'(ch_done_o), 64'(0));
        check("tmo_sb", 64'(sched_busy_o), 64'(0));
`else
        repeat (30) tick();
        check("notmo_sb", 64'(sched_busy_o), 64'(1));
        check("notmo_busy", 64'(ch_busy_o), 64'(4'b0100));
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        check("notmo_done", 64'(ch_done_o), 64'(4'b0100));
        tick();
`endif

        // Reset mid-transfer
        pulse_go(4'b0010, 32'd16);
        wait_go();
        pulse_go(4'b1100, 32'd16);
        check("mr_busy", 64'(ch_busy_o), 64'(4'b1110));
        do_reset();
        check("mr_busy0", 64'(ch_busy_o), 64'(0));
        check("mr_sb0", 64'(sched_busy_o), 64'(0));
        check("mr_go0", 64'(eng_go_o), 64'(0));
        check("mr_done0", 64'(ch_done_o), 64'(0));
        check("mr_err0", 64'(ch_err_o), 64'(0));
        check("mr_addr0", 64'(err_addr_o), 64'(0));
        check("mr_src0", 64'(eng_src_o), 64'(0));
        tick();
        check("mr_nopulse", 64'(ch_done_o | ch_err_o), 64'(0));
        pulse_go(4'b1001, 32'd16);
        run_one(0, 3);
        run_one(3, 3);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
